// File: rtl/branch_cache_update_ctrl_pkg.sv
// rtl/branch_cache_update_ctrl_pkg.sv - shared types and constants for the branch cache update path
package branch_cache_update_ctrl_pkg;

  // Set-index field of an instruction address used for same-set conflict detection
  localparam int SET_MSB = 4;
  localparam int SET_LSB = 2;
  localparam int SET_W   = SET_MSB - SET_LSB + 1;

  // One queued update: resolved-outcome flag, branch target, branch instruction address
  typedef struct packed {
    logic        hit;
    logic [31:0] addr;
    logic [31:0] inst_addr;
  } bc_entry_t;

  localparam int ENTRY_W = $bits(bc_entry_t);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } bc_state_t;

endpackage

// File: rtl/branch_cache_update_ctrl_fifo.sv
// rtl/branch_cache_update_ctrl_fifo.sv - synchronous update-entry queue with clear
module branch_update_fifo
  import branch_cache_update_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               iCLOCK,
  input  logic               iRESET,
  input  logic               iCLEAR,
  input  logic               iPUSH,
  input  logic [ENTRY_W-1:0] iPUSH_DATA,
  input  logic               iPOP,
  output logic [ENTRY_W-1:0] oHEAD,
  output logic               oFULL,
  output logic               oEMPTY
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  assign oFULL   = (count_q == CNT_FULL);
  assign oEMPTY  = (count_q == '0);
  assign do_push = iPUSH && !oFULL;
  assign do_pop  = iPOP && !oEMPTY;
  assign oHEAD   = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; clear discards everything queued
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (iCLEAR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between the pointers
  always_ff @(posedge iCLOCK) begin
    if (do_push && !iCLEAR) mem_q[wr_ptr_q] <= iPUSH_DATA;
  end

endmodule

// File: rtl/branch_cache_update_ctrl.sv
// rtl/branch_cache_update_ctrl.sv - arbitrates branch updates, queues them and drains into the branch cache
module branch_cache_update_ctrl
  import branch_cache_update_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STALL_MAX  = 3
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iFLUSH,
  input  logic        iREQ0_VALID,
  output logic        oREQ0_BUSY,
  input  logic        iREQ0_HIT,
  input  logic [31:0] iREQ0_ADDR,
  input  logic [31:0] iREQ0_INST_ADDR,
  input  logic        iREQ1_VALID,
  output logic        oREQ1_BUSY,
  input  logic        iREQ1_HIT,
  input  logic [31:0] iREQ1_ADDR,
  input  logic [31:0] iREQ1_INST_ADDR,
  input  logic        iSEARCH_STB,
  input  logic [31:0] iSEARCH_INST_ADDR,
  output logic        oJUMP_STB,
  output logic        oJUMP_HIT,
  output logic [31:0] oJUMP_ADDR,
  output logic [31:0] oJUMP_INST_ADDR,
  output logic        oCACHE_FLUSH,
  output logic        oEMPTY
);

  localparam int STALL_W = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

  bc_state_t          state_q;
  bc_state_t          state_d;
  logic               cache_flush_q;
  logic               cache_flush_d;
  logic               rr_q;
  logic               rr_d;
  logic [STALL_W-1:0] stall_q;
  logic [STALL_W-1:0] stall_d;

  logic               busy_all;
  logic               grant0;
  logic               grant1;
  logic               push;
  bc_entry_t          push_entry;
  logic               conflict;
  logic               jump_stb;

  logic [ENTRY_W-1:0] fifo_head;
  bc_entry_t          head;
  logic               fifo_full;
  logic               fifo_empty;

  // Only the set-index bits of the search address take part in conflict detection
  logic [28:0]        unused_search_bits;
  assign unused_search_bits = {iSEARCH_INST_ADDR[31:SET_MSB+1], iSEARCH_INST_ADDR[SET_LSB-1:0]};

  // FSM next state: any flush request (re)enters FLUSH for exactly one cycle
  always_comb begin
    state_d       = ST_RUN;
    cache_flush_d = 1'b0;
    if (iFLUSH) begin
      state_d       = ST_FLUSH;
      cache_flush_d = 1'b1;
    end
  end

  // Round-robin arbitration; full queue, flush and reset block both requesters
  always_comb begin
    busy_all = fifo_full || (state_q == ST_FLUSH) || iFLUSH || iRESET;
    grant0   = iREQ0_VALID && !busy_all && (!iREQ1_VALID || !rr_q);
    grant1   = iREQ1_VALID && !busy_all && (!iREQ0_VALID || rr_q);
    push     = grant0 || grant1;
    push_entry.hit       = grant1 ? iREQ1_HIT       : iREQ0_HIT;
    push_entry.addr      = grant1 ? iREQ1_ADDR      : iREQ0_ADDR;
    push_entry.inst_addr = grant1 ? iREQ1_INST_ADDR : iREQ0_INST_ADDR;
    rr_d = rr_q;
    if (iFLUSH) begin
      rr_d = 1'b0;
    end else if (iREQ0_VALID && iREQ1_VALID && !busy_all) begin
      rr_d = !rr_q;
    end
  end

  assign oREQ0_BUSY = busy_all || (iREQ1_VALID && rr_q);
  assign oREQ1_BUSY = busy_all || (iREQ0_VALID && !rr_q);

  assign head = bc_entry_t'(fifo_head);

  // Drain decision: hold the head while the search reads its set, up to the stall limit
  always_comb begin
    conflict = iSEARCH_STB &&
               (iSEARCH_INST_ADDR[SET_MSB:SET_LSB] == head.inst_addr[SET_MSB:SET_LSB]);
    jump_stb = (state_q == ST_RUN) && !iFLUSH && !fifo_empty &&
               (!conflict || (stall_q == STALL_LIM));
    stall_d  = stall_q;
    if (iFLUSH || jump_stb || fifo_empty) begin
      stall_d = '0;
    end else if (conflict && (stall_q != STALL_LIM)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  // Registered controller state
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q       <= ST_RUN;
      cache_flush_q <= 1'b0;
      rr_q          <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      cache_flush_q <= cache_flush_d;
      rr_q          <= rr_d;
      stall_q       <= stall_d;
    end
  end

  branch_update_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iCLOCK     (iCLOCK),
    .iRESET     (iRESET),
    .iCLEAR     (iFLUSH),
    .iPUSH      (push),
    .iPUSH_DATA (push_entry),
    .iPOP       (jump_stb),
    .oHEAD      (fifo_head),
    .oFULL      (fifo_full),
    .oEMPTY     (fifo_empty)
  );

  assign oJUMP_STB       = jump_stb;
  assign oJUMP_HIT       = head.hit;
  assign oJUMP_ADDR      = head.addr;
  assign oJUMP_INST_ADDR = head.inst_addr;
  assign oCACHE_FLUSH    = cache_flush_q;
  assign oEMPTY          = fifo_empty;

endmodule

// File: tb/tb_branch_cache_update_ctrl.sv
// tb/tb_branch_cache_update_ctrl.sv - self-checking bench for branch_cache_update_ctrl
module tb_branch_cache_update_ctrl;

  localparam int DEPTH = 4;
  localparam int SMAX  = 3;

  logic        clk = 1'b0;
  logic        rst, fl, v0, v1, h0, h1, s;
  logic [31:0] a0, a1, ia0, ia1, sa;
  logic        busy0, busy1, stb, jhit, cf, empty;
  logic [31:0] jaddr, jia;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_cache_update_ctrl #(.FIFO_DEPTH(DEPTH), .STALL_MAX(SMAX)) dut (
    .iCLOCK(clk), .iRESET(rst), .iFLUSH(fl),
    .iREQ0_VALID(v0), .oREQ0_BUSY(busy0), .iREQ0_HIT(h0), .iREQ0_ADDR(a0), .iREQ0_INST_ADDR(ia0),
    .iREQ1_VALID(v1), .oREQ1_BUSY(busy1), .iREQ1_HIT(h1), .iREQ1_ADDR(a1), .iREQ1_INST_ADDR(ia1),
    .iSEARCH_STB(s), .iSEARCH_INST_ADDR(sa),
    .oJUMP_STB(stb), .oJUMP_HIT(jhit), .oJUMP_ADDR(jaddr), .oJUMP_INST_ADDR(jia),
    .oCACHE_FLUSH(cf), .oEMPTY(empty)
  );

  // ---------------- reference model ----------------
  typedef struct { logic hit; logic [31:0] addr; logic [31:0] ia; } ent_t;
  ent_t mq[$];
  bit   m_rr, m_inflush, m_cf, m_acc0, m_acc1, m_estb, m_conf;
  int   m_stall;

  function automatic logic [31:0] addr_of(input logic [31:0] x);
    return (x & 32'hFFFF_F000) + 32'h0000_1000;
  endfunction

  function automatic logic hit_of(input logic [31:0] x);
    return ~x[3];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr = 0; m_stall = 0; m_inflush = 0; m_cf = 0;
  endtask

  task automatic model_check();
    bit busy_all;
    ent_t hd;
    if (rst) model_reset();
    busy_all = (mq.size() == DEPTH) || m_inflush || fl || rst;
    m_acc0 = v0 && !busy_all && (!v1 || !m_rr);
    m_acc1 = v1 && !busy_all && (!v0 || m_rr);
    m_conf = 0;
    if (mq.size() > 0) begin
      hd = mq[0];
      m_conf = s && (sa[4:2] == hd.ia[4:2]);
    end
    m_estb = !m_inflush && !fl && (mq.size() > 0) && (!m_conf || m_stall == SMAX);
    chk("m_busy0", busy0, busy_all || (v1 && m_rr));
    chk("m_busy1", busy1, busy_all || (v0 && !m_rr));
    chk("m_stb", stb, m_estb);
    chk("m_empty", empty, mq.size() == 0);
    chk("m_cflush", cf, m_cf);
    if (m_estb) begin
      chk("m_jhit", jhit, hd.hit);
      chk("m_jaddr", jaddr, hd.addr);
      chk("m_jia", jia, hd.ia);
    end
  endtask

  task automatic model_advance();
    ent_t e;
    if (rst) begin model_reset(); return; end
    if (fl) begin model_reset(); m_inflush = 1; m_cf = 1; return; end
    m_inflush = 0; m_cf = 0;
    if (m_estb || mq.size() == 0) m_stall = 0;
    else if (m_conf && m_stall < SMAX) m_stall++;
    if (m_estb) void'(mq.pop_front());
    if (m_acc0) begin e.hit = h0; e.addr = a0; e.ia = ia0; mq.push_back(e); end
    else if (m_acc1) begin e.hit = h1; e.addr = a1; e.ia = ia1; mq.push_back(e); end
    if (v0 && v1 && (m_acc0 || m_acc1)) m_rr = !m_rr;
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    model_advance();
  endtask

  task automatic drv0(input logic v, input logic [31:0] x);
    v0 = v; ia0 = x; a0 = addr_of(x); h0 = hit_of(x);
  endtask

  task automatic drv1(input logic v, input logic [31:0] x);
    v1 = v; ia1 = x; a1 = addr_of(x); h1 = hit_of(x);
  endtask

  function automatic logic [31:0] rand_ia();
    logic [31:0] r;
    r = $urandom();
    return {r[31:5], 2'b00, r[0], 2'b00};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic v0, v1; logic [31:0] ia0, ia1; logic s; logic [31:0] sa;
    logic eb0, eb1, estb, eempty, ecf; logic [31:0] eia;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; fl = 0; s = 0; sa = 0;
    drv0(0, 0); drv1(0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_stb", stb, 0);
    chk("rst_cflush", cf, 0);
    chk("rst_busy0", busy0, 1);
    chk("rst_busy1", busy1, 1);
    rst = 0;

    //                v0 v1 ia0       ia1      s  sa        eb0 eb1 stb emp cf eia
    tbl.push_back('{0, 0, 32'h0,     32'h0,   0, 32'h0,   0, 0, 0, 1, 0, 32'h0});
    tbl.push_back('{1, 0, 32'h1004,  32'h0,   0, 32'h0,   0, 1, 0, 1, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,     32'h0,   0, 32'h0,   0, 0, 1, 0, 0, 32'h1004});
    tbl.push_back('{0, 0, 32'h0,     32'h0,   0, 32'h0,   0, 0, 0, 1, 0, 32'h0});
    tbl.push_back('{1, 1, 32'h100,   32'h200, 0, 32'h0,   0, 1, 0, 1, 0, 32'h0});
    tbl.push_back('{1, 1, 32'h110,   32'h200, 0, 32'h0,   1, 0, 1, 0, 0, 32'h100});
    tbl.push_back('{1, 1, 32'h110,   32'h210, 0, 32'h0,   0, 1, 1, 0, 0, 32'h200});
    tbl.push_back('{1, 1, 32'h120,   32'h210, 0, 32'h0,   1, 0, 1, 0, 0, 32'h110});
    tbl.push_back('{0, 0, 32'h0,     32'h0,   0, 32'h0,   0, 0, 1, 0, 0, 32'h210});
    tbl.push_back('{0, 0, 32'h0,     32'h0,   0, 32'h0,   0, 0, 0, 1, 0, 32'h0});
    tbl.push_back('{1, 0, 32'h104,   32'h0,   0, 32'h0,   0, 1, 0, 1, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,     32'h0,   1, 32'h204, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,     32'h0,   1, 32'h204, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,     32'h0,   0, 32'h0,   0, 0, 1, 0, 0, 32'h104});
    tbl.push_back('{1, 0, 32'h104,   32'h0,   0, 32'h0,   0, 1, 0, 1, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,     32'h0,   1, 32'h208, 0, 0, 1, 0, 0, 32'h104});
    tbl.push_back('{0, 0, 32'h0,     32'h0,   0, 32'h0,   0, 0, 0, 1, 0, 32'h0});

    for (int i = 0; i < tbl.size(); i++) begin
      drv0(tbl[i].v0, tbl[i].ia0);
      drv1(tbl[i].v1, tbl[i].ia1);
      s = tbl[i].s; sa = tbl[i].sa;
      @(negedge clk);
      model_check();
      chk($sformatf("tbl%0d_busy0", i), busy0, tbl[i].eb0);
      chk($sformatf("tbl%0d_busy1", i), busy1, tbl[i].eb1);
      chk($sformatf("tbl%0d_stb", i), stb, tbl[i].estb);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].eempty);
      chk($sformatf("tbl%0d_cflush", i), cf, tbl[i].ecf);
      if (tbl[i].estb) begin
        chk($sformatf("tbl%0d_jia", i), jia, tbl[i].eia);
        chk($sformatf("tbl%0d_jaddr", i), jaddr, addr_of(tbl[i].eia));
        chk($sformatf("tbl%0d_jhit", i), jhit, hit_of(tbl[i].eia));
      end
      @(posedge clk);
      #1;
      model_advance();
    end

    // Full queue under a held same-set search, then the forced drain
    s = 1; sa = 32'h304; drv1(0, 0);
    drv0(1, 32'h104); tick();
    drv0(1, 32'h124); #1 chk("full_hold1", stb, 0); tick();
    drv0(1, 32'h144); #1 chk("full_hold2", stb, 0); tick();
    drv0(1, 32'h164); #1 chk("full_hold3", stb, 0); tick();
    drv0(1, 32'h184);
    #1;
    chk("full_busy0", busy0, 1);
    chk("full_busy1", busy1, 1);
    chk("full_forced_stb", stb, 1);
    chk("full_forced_jia", jia, 32'h104);
    tick();
    #1;
    chk("full_after_busy0", busy0, 0);
    chk("full_after_stb", stb, 0);
    tick();
    drv0(0, 0); s = 0;
    repeat (4) tick();
    chk("full_drained", empty, 1);

    // Flush with three entries queued
    s = 1; sa = 32'h304;
    drv0(1, 32'h104); tick();
    drv0(1, 32'h124); tick();
    drv0(1, 32'h144); tick();
    drv0(1, 32'h164); drv1(1, 32'h404); fl = 1;
    #1;
    chk("fl_req_stb", stb, 0);
    chk("fl_req_busy0", busy0, 1);
    chk("fl_req_busy1", busy1, 1);
    chk("fl_req_cflush", cf, 0);
    tick();
    fl = 0; s = 0;
    #1;
    chk("fl_cyc_cflush", cf, 1);
    chk("fl_cyc_stb", stb, 0);
    chk("fl_cyc_empty", empty, 1);
    chk("fl_cyc_busy0", busy0, 1);
    chk("fl_cyc_busy1", busy1, 1);
    tick();
    #1;
    chk("fl_post_cflush", cf, 0);
    chk("fl_post_empty", empty, 1);
    chk("fl_post_busy0", busy0, 0);
    chk("fl_post_busy1", busy1, 1);
    tick();
    drv0(0, 0);
    #1;
    chk("fl_first_stb", stb, 1);
    chk("fl_first_jia", jia, 32'h164);
    tick();
    drv1(0, 0);
    tick();
    tick();

    // Asynchronous reset in the middle of a drain and during a flush pulse
    drv0(1, 32'h500); drv1(1, 32'h600); tick();
    drv0(0, 0); drv1(0, 0);
    #1 chk("rstmid_pre_stb", stb, 1);
    rst = 1;
    #1;
    chk("rstmid_stb", stb, 0);
    chk("rstmid_empty", empty, 1);
    model_reset();
    @(posedge clk); #1 rst = 0;
    fl = 1; tick();
    fl = 0;
    #1 chk("rstfl_pre_cflush", cf, 1);
    rst = 1;
    #1 chk("rstfl_cflush", cf, 0);
    model_reset();
    @(posedge clk); #1 rst = 0;
    drv0(1, 32'h700); drv1(1, 32'h800);
    #1;
    chk("rst_rr_busy0", busy0, 0);
    chk("rst_rr_busy1", busy1, 1);
    tick();
    drv0(1, 32'h710);
    #1;
    chk("rst_rr2_busy0", busy0, 1);
    chk("rst_rr2_busy1", busy1, 0);
    tick();
    drv0(0, 0); drv1(0, 0);
    repeat (3) tick();

    // Randomized traffic against the model; data held while a request waits
    m_acc0 = 0; m_acc1 = 0;
    for (int c = 0; c < 500; c++) begin
      if (!(v0 && !m_acc0)) begin
        v0 = ($urandom_range(0, 3) != 0); ia0 = rand_ia(); a0 = $urandom(); h0 = 1'($urandom_range(0, 1));
      end
      if (!(v1 && !m_acc1)) begin
        v1 = ($urandom_range(0, 3) != 0); ia1 = rand_ia(); a1 = $urandom(); h1 = 1'($urandom_range(0, 1));
      end
      s   = 1'($urandom_range(0, 1));
      sa  = rand_ia();
      fl  = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0; fl = 0; s = 0; drv0(0, 0); drv1(0, 0);
    repeat (6) tick();
    chk("final_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
